mult4_mac_stream: RTL and testbench
===================================

Name: mult4_mac_stream

Overview:
- Streaming multiply-accumulate stage built around the team's existing 4x4 combinational multiplier (ports x, y, o; 8-bit product).
- Accepts a valid/ready stream of 4-bit operand pairs grouped into frames by a last flag.
- Registers each operand pair ahead of the multiplier and accumulates the 8-bit products.
- Emits one accumulated sum per frame on a valid/ready output, with item count and overflow flag.

Parameters:
- ACC_W, 16, accumulator and out_acc width in bits; must be >= 8.
- CNT_W, 8, out_count width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can take the operand pair this cycle.
- in_x  in  4  multiplicand.
- in_y  in  4  multiplier.
- in_last  in  1  this pair closes the current frame.
- out_valid  out  1  frame result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_acc  out  ACC_W  sum of x*y over the frame, modulo 2^ACC_W.
- out_count  out  CNT_W  items in the frame; saturates at 2^CNT_W-1.
- out_ovf  out  1  sticky: accumulator carried out at least once in the frame.

Behaviour:
- Reset (rst=1 at an edge): s1_valid=0, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0. Any partial frame or held result is discarded. rst overrides every other input in that cycle.
- Stage 1 (operand register):
  - Holds s1_valid, s1_x, s1_y, s1_last.
  - The multiplier computes p = s1_x*s1_y combinationally from the stage-1 register.
  - Input transfer occurs when in_valid && in_ready.
- Stage 2 (accumulate):
  - s2_take = s1_valid && !(s1_last && out_valid && !out_ready).
  - A non-last item may accumulate while a result is being held. Only a last item stalls on a held result.
- in_ready = !s1_valid || s2_take. It is combinational from out_valid/out_ready and registered state only, never from in_valid.
- Stage 1 update: on input transfer, load the operands and set s1_valid=1. Otherwise, if s2_take, clear s1_valid.
- On s2_take with s1_last=0:
  - acc <= acc + zero-extended p, modulo 2^ACC_W.
  - cnt <= cnt+1, saturating.
  - ovf <= ovf | carry-out.
- On s2_take with s1_last=1:
  - out_acc <= acc+p, out_count <= sat(cnt+1), out_ovf <= ovf|carry.
  - out_valid <= 1.
  - acc, cnt, ovf <= 0.
- out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle; a load wins.
- A result-register load and a consumer handshake in the same cycle are legal, giving one result per cycle throughput.
- Latency: a pair accepted at edge N is in stage 1 after N and consumed at N+1. For a last pair, out_valid is high after edge N+1, i.e. 2 cycles from acceptance.
- Steady-state throughput is one pair per cycle with out_ready=1.
- Frame boundaries:
  - A frame has at least one item. A single item with in_last=1 is a complete frame.
  - No empty-frame output is ever produced.
- out_* are stable while out_valid && !out_ready.
- in_x, in_y and in_last are don't-care when in_valid=0.

Decomposition:
- Shared package holds OP_W=4, PROD_W=8, and default ACC_W and CNT_W.
- Package also holds a result struct typedef {acc, count, ovf} used by the output register and the bench.
- One sub-module: the existing 4x4 multiplier, instantiated unchanged between stage 1 and stage 2.
- The accumulate and output register logic stays inline.

Test Plan:
- Single-item frame (15,15,last) with out_ready=1 -> out_valid 2 cycles after acceptance; out_acc=225, out_count=1, out_ovf=0; held 1 cycle.
- Frame (3,5),(2,7),(15,1,last) back-to-back -> out_acc=44, out_count=3, out_ovf=0; in_ready stays 1 throughout.
- ACC_W=8, frame (15,15),(15,15,last) -> out_acc=194 (450 mod 256), out_ovf=1. The next frame (1,1,last) gives out_acc=1, out_ovf=0.
- Backpressure: frame A=(2,3,last) then frame B=(4,4),(5,5,last), with out_ready=0 -> A held stable at 6.
  - (4,4) still accumulates; in_ready drops once (5,5,last) sits in stage 1.
  - Raising out_ready consumes A; B=41, count 2 appears the next cycle.
- Reset mid-frame: (7,7),(6,6) then rst for 1 cycle, then (1,2,last) -> out_acc=2, out_count=1. No output was produced for the discarded items.
- Exhaustive: 256 single-item frames covering all x,y with out_ready=1 -> one result per cycle; out_acc=x*y each time; no in_ready deassertion.

Source files
------------

// File: rtl/mult4_mac_stream_pkg.sv
// Shared constants and result type for the streaming 4x4 multiply-accumulate stage.
package mult4_mac_stream_pkg;

  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  // Per-frame result at the default widths.
  typedef struct packed {
    logic [ACC_W_DEF-1:0] acc;
    logic [CNT_W_DEF-1:0] count;
    logic                 ovf;
  } mac_res_t;

endpackage

// File: rtl/mult4_mac_stream_mult4.sv
// Existing 4x4 unsigned combinational multiplier, 8-bit product.
module mult4_mac_stream_mult4
  import mult4_mac_stream_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] o
);

  assign o = PROD_W'(x) * PROD_W'(y);

endmodule

// File: rtl/mult4_mac_stream.sv
// Streaming MAC: registers operand pairs, multiplies, accumulates per frame and
// emits one {sum, count, overflow} result per frame on a valid/ready output.
module mult4_mac_stream
  import mult4_mac_stream_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_x,
  input  logic [OP_W-1:0]  in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Output register layout, sized to this instance's parameters.
  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_x_q, s1_x_d;
  logic [OP_W-1:0]  s1_y_q, s1_y_d;
  logic             s1_last_q, s1_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  res_t             res_q, res_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              s2_take;
  logic              in_fire;

  mult4_mac_stream_mult4 u_mult (
    .x (s1_x_q),
    .y (s1_y_q),
    .o (prod)
  );

  // Only a closing item has to wait for a held result; partial sums keep flowing.
  assign s2_take  = s1_valid_q && !(s1_last_q && out_valid_q && !out_ready);
  assign in_ready = !s1_valid_q || s2_take;
  assign in_fire  = in_valid && in_ready;

  // Widened add exposes the carry-out for the sticky overflow flag.
  assign sum     = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
  assign carry   = sum[ACC_W];
  assign cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state for operand register, accumulator and result register.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    out_valid_d = out_valid_q && !out_ready;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_x_d     = in_x;
      s1_y_d     = in_y;
      s1_last_d  = in_last;
    end else if (s2_take) begin
      s1_valid_d = 1'b0;
    end

    if (s2_take) begin
      if (s1_last_q) begin
        // Close the frame: a load here wins over a same-cycle consume.
        res_d.acc   = sum[ACC_W-1:0];
        res_d.count = cnt_nxt;
        res_d.ovf   = ovf_q | carry;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_nxt;
        ovf_d = ovf_q | carry;
      end
    end
  end

  // State registers with synchronous reset discarding partial frames and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = res_q.acc;
  assign out_count = res_q.count;
  assign out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_mult4_mac_stream.sv
// Scoreboard bench: two instances (default widths and ACC_W=8) share one stimulus
// stream; accepted pairs feed a frame-sum model, results are popped by monitors.
module tb_mult4_mac_stream;
  import mult4_mac_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_x, in_y;
  logic       in_last;
  logic       out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_acc;
  logic [7:0]  out_count;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_acc8;
  logic [7:0]  out_count8;

  always #5 clk = ~clk;

  mult4_mac_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  mult4_mac_stream #(.ACC_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_acc(out_acc8), .out_count(out_count8), .out_ovf(out_ovf8)
  );

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] count;
    logic       ovf;
  } res8_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a running integer sum and item count.
  int       fr_sum = 0;
  int       fr_n   = 0;
  mac_res_t q16[$];
  res8_t    q8[$];

  always @(negedge clk) begin
    if (rst) begin
      fr_sum = 0;
      fr_n   = 0;
      q16.delete();
      q8.delete();
    end else if (in_valid && in_ready) begin
      mac_res_t e16;
      res8_t    e8;
      fr_sum += int'(in_x) * int'(in_y);
      fr_n++;
      if (in_last) begin
        e16.acc   = 16'(fr_sum % 65536);
        e16.count = 8'((fr_n > 255) ? 255 : fr_n);
        e16.ovf   = (fr_sum >= 65536);
        e8.acc    = 8'(fr_sum % 256);
        e8.count  = 8'((fr_n > 255) ? 255 : fr_n);
        e8.ovf    = (fr_sum >= 256);
        q16.push_back(e16);
        q8.push_back(e8);
        fr_sum = 0;
        fr_n   = 0;
      end
    end
  end

  // Output monitor, default-width instance.
  bit          hold16 = 0;
  logic [24:0] hv16;
  always @(negedge clk) begin
    if (rst) hold16 = 0;
    else begin
      if (hold16) chk("hold16", {out_valid, out_acc, out_count, out_ovf}, {1'b1, hv16});
      hold16 = out_valid && !out_ready;
      hv16   = {out_acc, out_count, out_ovf};
      if (out_valid && out_ready) begin
        if (q16.size() == 0) chk("unexpected_out16", 1, 0);
        else begin
          mac_res_t e;
          e = q16.pop_front();
          chk("acc16", out_acc, e.acc);
          chk("count16", out_count, e.count);
          chk("ovf16", out_ovf, e.ovf);
        end
      end
    end
  end

  // Output monitor, ACC_W=8 instance.
  bit          hold8 = 0;
  logic [16:0] hv8;
  always @(negedge clk) begin
    if (rst) hold8 = 0;
    else begin
      if (hold8) chk("hold8", {out_valid8, out_acc8, out_count8, out_ovf8}, {1'b1, hv8});
      hold8 = out_valid8 && !out_ready;
      hv8   = {out_acc8, out_count8, out_ovf8};
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) chk("unexpected_out8", 1, 0);
        else begin
          res8_t e;
          e = q8.pop_front();
          chk("acc8", out_acc8, e.acc);
          chk("count8", out_count8, e.count);
          chk("ovf8", out_ovf8, e.ovf);
        end
      end
    end
  end

  // Random consumer backpressure when enabled.
  bit rand_rdy = 0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one pair and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [3:0] x, input logic [3:0] y, input bit last,
                      output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q16.size() == 0 && q8.size() == 0) begin
        idle(2);
        return;
      end
    end
    chk("drain_timeout", 1, 0);
    idle(1);
  endtask

  initial begin
    int st, tot;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_valid8", out_valid8, 0);
    @(posedge clk); #1;

    // Single-item frame: latency 2, held one cycle
    send(4'd15, 4'd15, 1'b1, st);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_edge1", out_valid, 0);
    @(negedge clk); chk("lat_edge2", out_valid, 1);
    chk("single_acc", out_acc, 225);
    @(negedge clk); chk("single_held1", out_valid, 0);
    @(posedge clk); #1;

    // Back-to-back three-item frame, no stalls
    tot = 0;
    send(4'd3, 4'd5, 1'b0, st);  tot += st;
    send(4'd2, 4'd7, 1'b0, st);  tot += st;
    send(4'd15, 4'd1, 1'b1, st); tot += st;
    chk("b2b_stalls", tot, 0);
    drain();

    // Overflow on the narrow accumulator, then a clean frame
    send(4'd15, 4'd15, 1'b0, st);
    send(4'd15, 4'd15, 1'b1, st);
    send(4'd1, 4'd1, 1'b1, st);
    drain();

    // Backpressure: A held, B's first item accumulates, B's last stalls
    out_ready = 1'b0;
    send(4'd2, 4'd3, 1'b1, st);
    send(4'd4, 4'd4, 1'b0, st);
    send(4'd5, 4'd5, 1'b1, st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_A_valid", out_valid, 1);
    chk("bp_A_acc", out_acc, 6);
    repeat (3) @(negedge clk);
    chk("bp_A_still", out_acc, 6);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_B_valid", out_valid, 1);
    chk("bp_B_acc", out_acc, 41);
    chk("bp_B_count", out_count, 2);
    @(posedge clk); #1;
    drain();

    // Reset mid-frame discards partial items
    send(4'd7, 4'd7, 1'b0, st);
    send(4'd6, 4'd6, 1'b0, st);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'd1, 4'd2, 1'b1, st);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_acc", out_acc, 2);
    chk("post_rst_count", out_count, 1);
    @(posedge clk); #1;
    drain();

    // Exhaustive single-item frames at full rate
    tot = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        send(4'(x), 4'(y), 1'b1, st);
        tot += st;
      end
    chk("exh_stalls", tot, 0);
    drain();

    // Long frame: count saturation
    for (int i = 0; i < 300; i++) send(4'd1, 4'd1, (i == 299), st);
    drain();

    // Random frames with random gaps and consumer backpressure
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(4'($urandom), 4'($urandom), (i == 399) || ($urandom_range(0, 3) == 0), st);
    end
    drain();
    rand_rdy = 0;
    #2 out_ready = 1'b1;
    idle(3);

    chk("q16_empty", q16.size(), 0);
    chk("q8_empty", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
